// File: rtl/seq_multiplier.sv
// Iterative N x N multiplier using radix-2 Booth recoding over N+1 steps.
// Handles signed or unsigned operands per operation; valid/ready on both sides.
module seq_multiplier #(
  parameter  int N  = 8,
  localparam int CW = $clog2(N+2)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  input  logic           is_signed,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] P,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state_q;
  logic signed [N:0]     mcand_q;
  logic signed [N+1:0]   acc_q;
  logic [N:0]            q_q;
  logic                  qm1_q;
  logic [CW-1:0]         cnt_q;
  logic [2*N-1:0]        p_q;

  logic signed [N:0]     a_ext, b_ext;
  logic signed [N+1:0]   mcand_w, sum_d;
  logic signed [2*N+3:0] sh_d;

  always_comb begin
    a_ext   = {is_signed & A[N-1], A};
    b_ext   = {is_signed & B[N-1], B};
    mcand_w = {mcand_q[N], mcand_q};
    // Booth pair {q0, q-1}: 01 add, 10 subtract, otherwise hold
    case ({q_q[0], qm1_q})
      2'b01:   sum_d = acc_q + mcand_w;
      2'b10:   sum_d = acc_q - mcand_w;
      default: sum_d = acc_q;
    endcase
    sh_d = $signed({sum_d, q_q, qm1_q}) >>> 1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mcand_q <= a_ext;
            q_q     <= b_ext;
            acc_q   <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= CW'(N+1);
            state_q <= CALC;
          end
        end
        CALC: begin
          acc_q <= sh_d[2*N+3:N+2];
          q_q   <= sh_d[N+1:1];
          qm1_q <= sh_d[0];
          cnt_q <= cnt_q - CW'(1);
          // Final step: low 2N bits of the shifted {acc, q} are the product
          if (cnt_q == CW'(1)) begin
            p_q     <= sh_d[2*N:1];
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign P         = p_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier at N=4: latency, signed corners, exhaustive
// products, backpressure, asynchronous reset mid-operation and back-to-back flow.
module tb_seq_multiplier;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] A = '0;
  logic [N-1:0] B = '0;
  logic         is_signed = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [2*N-1:0] P;
  logic         busy;

  int errors = 0;
  int checks = 0;

  seq_multiplier #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .is_signed(is_signed), .out_valid(out_valid),
    .out_ready(out_ready), .P(P), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one operation; returns product and edges from accept to out_valid.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                        output logic [2*N-1:0] p, output int lat);
    @(negedge clk);
    in_valid = 1'b1; A = a; B = b; is_signed = s; out_ready = 1'b0;
    lat = -1;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 0) begin
        in_valid  = 1'b0;
        A         = 4'($urandom);
        B         = 4'($urandom);
        is_signed = 1'($urandom);
      end
    end while (!out_valid && lat < 30);
    p = P;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  logic [2*N-1:0] p;
  int             lat;
  logic [2*N-1:0] exp_p;
  logic [2*N-1:0] bb_exp [3];
  logic [N-1:0]   bb_a [3];
  logic [N-1:0]   bb_b [3];
  logic           bb_s [3];
  int             bb_cyc [3];
  logic [2*N-1:0] bb_p [3];
  int             n_out, idx;

  initial begin
    // Reset state
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_P", 32'(P), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Directed products
    run_op(4'd15, 4'd15, 1'b0, p, lat);
    chk("u15x15_P", 32'(p), 32'hE1);
    chk("u15x15_lat", 32'(lat), 32'd5);
    run_op(4'b1000, 4'b1000, 1'b1, p, lat);
    chk("s-8x-8_P", 32'(p), 32'h40);
    chk("s-8x-8_lat", 32'(lat), 32'd5);
    run_op(4'b1000, 4'b1000, 1'b0, p, lat);
    chk("u8x8_P", 32'(p), 32'd64);
    run_op(4'b1000, 4'd7, 1'b1, p, lat);
    chk("s-8x7_P", 32'(p), 32'hC8);
    run_op(4'd8, 4'd7, 1'b0, p, lat);
    chk("u8x7_P", 32'(p), 32'd56);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_P_held", 32'(P), 32'd56);

    // Exhaustive, both modes
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++) begin
          run_op(4'(a), 4'(b), 1'(s), p, lat);
          if (s == 1) exp_p = 8'($signed(4'(a)) * $signed(4'(b)));
          else        exp_p = 8'(a * b);
          chk($sformatf("ex_s%0d_%0dx%0d", s, a, b), 32'(p), 32'(exp_p));
          chk("ex_lat", 32'(lat), 32'd5);
        end

    // Backpressure
    @(negedge clk);
    in_valid = 1'b1; A = 4'd5; B = 4'd3; is_signed = 1'b0;
    @(negedge clk);
    A = 4'd2; B = 4'd2;
    chk("bp_busy_calc", 32'(busy), 32'd1);
    lat = 0;
    while (!out_valid && lat < 30) begin @(negedge clk); lat++; end
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_P", 32'(P), 32'd15);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("bp_xfer_out_valid", 32'(out_valid), 32'd0);
    chk("bp_xfer_in_ready", 32'(in_ready), 32'd1);
    chk("bp_xfer_P", 32'(P), 32'd15);
    @(negedge clk);
    chk("bp_no_accept", 32'(busy), 32'd0);

    // Asynchronous reset two cycles into CALC
    in_valid = 1'b1; A = 4'd7; B = 4'd7; is_signed = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_P", 32'(P), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(4'd3, 4'd5, 1'b0, p, lat);
    chk("post_rst_P", 32'(p), 32'd15);
    chk("post_rst_lat", 32'(lat), 32'd5);

    // Back-to-back with in_valid and out_ready held high
    bb_a = '{4'd2, 4'hD, 4'd15};
    bb_b = '{4'd3, 4'd5, 4'd14};
    bb_s = '{1'b0, 1'b1, 1'b0};
    bb_exp = '{8'd6, 8'hF1, 8'hD2};
    idx = 0; n_out = 0;
    @(negedge clk);
    in_valid = 1'b1; A = bb_a[0]; B = bb_b[0]; is_signed = bb_s[0]; out_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (in_valid && in_ready) begin
        @(negedge clk);
        idx++;
        if (idx < 3) begin A = bb_a[idx]; B = bb_b[idx]; is_signed = bb_s[idx]; end
        else in_valid = 1'b0;
      end else begin
        @(negedge clk);
      end
      if (out_valid) begin
        if (n_out < 3) begin bb_p[n_out] = P; bb_cyc[n_out] = cyc; end
        n_out++;
      end
    end
    out_ready = 1'b0;
    chk("bb_count", 32'(n_out), 32'd3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("bb_P%0d", i), 32'(bb_p[i]), 32'(bb_exp[i]));
    chk("bb_space01", 32'(bb_cyc[1] - bb_cyc[0]), 32'd7);
    chk("bb_space12", 32'(bb_cyc[2] - bb_cyc[1]), 32'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
